// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, issues one word request at a time, and
// buffers a single fetched instruction for decode with branch/JAL/JALR redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  input  logic        redirect_valid,
  input  logic        redirect_sel,
  input  logic [31:0] redirect_base_pc,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic        misalign_fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        fault_q, fault_d;

  logic        drain;
  logic        buf_free;
  logic        redirect_act;
  logic [31:0] target;

  // JALR clears bit 0 of rs1+imm; branch/JAL targets wrap modulo 2^32.
  function automatic logic [31:0] calc_target(
    input logic               sel,
    input logic        [31:0] base,
    input logic signed [31:0] imm,
    input logic        [31:0] alu
  );
    if (sel) begin
      return alu & 32'hFFFF_FFFE;
    end
    return base + $unsigned(imm);
  endfunction

  assign drain        = instr_valid_q && instr_ready;
  assign buf_free     = !instr_valid_q || instr_ready;
  assign redirect_act = redirect_valid &&
                        ((state_q == FETCH) || (state_q == WAIT) || (state_q == DRAIN));
  assign target       = calc_target(redirect_sel, redirect_base_pc, imm_ext, alu_result);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q && !drain;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fault_d       = fault_q;
    imem_req      = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req = buf_free && !redirect_valid;
        if (imem_req) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A request only leaves with the buffer free, so the load never collides.
        if (imem_valid) begin
          instr_valid_d = 1'b1;
          instr_d       = imem_rdata;
          instr_pc_d    = pc_q;
          pc_d          = pc_q + 32'd4;
          state_d       = FETCH;
        end
      end
      DRAIN: begin
        if (imem_valid) begin
          state_d = FETCH;
        end
      end
      HALT: instr_valid_d = 1'b0;
      default: state_d = IDLE;
    endcase

    // Redirect squashes the buffer and any response landing this cycle.
    if (redirect_act) begin
      instr_valid_d = 1'b0;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      if (target[1:0] != 2'b00) begin
        fault_d = 1'b1;
        pc_d    = pc_q;
        state_d = HALT;
      end else begin
        pc_d = target;
        case (state_q)
          WAIT:    state_d = imem_valid ? FETCH : DRAIN;
          DRAIN:   state_d = DRAIN;
          default: state_d = FETCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fault_q       <= fault_d;
    end
  end

  assign imem_addr      = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_pc_plus4 = instr_pc_q + 32'd4;
  assign misalign_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: variable-latency memory model returning
// ~addr as the instruction word, with a queue of expected PCs per scenario.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        redirect_valid = 1'b0;
  logic        redirect_sel = 1'b0;
  logic [31:0] redirect_base_pc = 32'h0;
  logic [31:0] imm_ext = 32'h0;
  logic [31:0] alu_result = 32'h0;
  logic        misalign_fault;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] req_q[$];

  int          mem_lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_valid      (imem_valid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_pc_plus4  (instr_pc_plus4),
    .redirect_valid  (redirect_valid),
    .redirect_sel    (redirect_sel),
    .redirect_base_pc(redirect_base_pc),
    .imm_ext         (imm_ext),
    .alu_result      (alu_result),
    .misalign_fault  (misalign_fault)
  );

  always #5 clk = ~clk;

  // Memory answers mem_lat cycles after the request; it ignores reset on purpose.
  always @(posedge clk) begin
    imem_valid <= 1'b0;
    if (imem_req) begin
      if (mem_lat <= 1) begin
        imem_valid <= 1'b1;
        imem_rdata <= ~imem_addr;
        pend       <= 1'b0;
      end else begin
        pend      <= 1'b1;
        pend_addr <= imem_addr;
        cnt       <= mem_lat - 1;
      end
    end else if (pend) begin
      if (cnt == 1) begin
        imem_valid <= 1'b1;
        imem_rdata <= ~pend_addr;
        pend       <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    mem_lat = 1;
    reset_n = 1'b0;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid got=%b exp=0", instr_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
    total++; if (misalign_fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b exp=0", misalign_fault); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, RESET_PC); end
    reset_n = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%b exp=0", imem_req); end
    tick();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL first_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_seq();
    logic [31:0] e;
    int last;
    exp_q.delete();
    req_q.delete();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    req_q.push_back(32'h0); req_q.push_back(32'h4); req_q.push_back(32'h8);
    last = -1;
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) begin
      if (imem_req && req_q.size() > 0) begin
        e = req_q.pop_front();
        total++; if (imem_addr !== e) begin bad++; $display("FAIL seq_addr got=%h exp=%h", imem_addr, e); end
      end
      if (instr_valid && instr_ready) begin
        e = exp_q.pop_front();
        total++; if (instr_pc !== e) begin bad++; $display("FAIL seq_pc got=%h exp=%h", instr_pc, e); end
        total++; if (instr !== ~e) begin bad++; $display("FAIL seq_instr got=%h exp=%h", instr, ~e); end
        total++; if (instr_pc_plus4 !== e + 32'd4) begin bad++; $display("FAIL seq_pc4 got=%h exp=%h", instr_pc_plus4, e + 32'd4); end
        if (last >= 0) begin
          total++; if (n - last !== 2) begin bad++; $display("FAIL seq_rate got=%0d exp=2", n - last); end
        end
        last = n;
      end
      tick();
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL seq_timeout got=%0d left exp=0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    int n;
    mem_lat = 1;
    do_reset();
    instr_ready = 1'b0;
    exp_q.delete();
    req_q.delete();
    exp_q.push_back(32'h0);
    req_q.push_back(32'h4);
    n = 0;
    while (!instr_valid && n < 10) begin tick(); n++; end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL bp_fill got=%b exp=1", instr_valid); end
    for (int i = 0; i < 5; i++) begin
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req got=%b exp=0", imem_req); end
      total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL bp_pc got=%h exp=0", instr_pc); end
      total++; if (instr !== 32'hFFFF_FFFF) begin bad++; $display("FAIL bp_instr got=%h exp=ffffffff", instr); end
      tick();
    end
    instr_ready = 1'b1;
    #1;
    e = exp_q.pop_front();
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL bp_release_valid got=%b exp=1", instr_valid); end
    total++; if (instr_pc !== e) begin bad++; $display("FAIL bp_release_pc got=%h exp=%h", instr_pc, e); end
    e = req_q.pop_front();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL bp_release_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== e) begin bad++; $display("FAIL bp_release_addr got=%h exp=%h", imem_addr, e); end
    tick();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL bp_after_drain got=%b exp=0", instr_valid); end
  endtask

  task automatic test_branch_wait();
    logic [31:0] e;
    int n;
    mem_lat = 3;
    do_reset();
    exp_q.delete();
    tick();
    tick();
    redirect_valid   = 1'b1;
    redirect_sel     = 1'b0;
    redirect_base_pc = 32'h0000_0100;
    imm_ext          = 32'hFFFF_FFF0;
    alu_result       = 32'h0;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL br_wait_req got=%b exp=0", imem_req); end
    tick();
    redirect_valid = 1'b0;
    #1;
    exp_q.push_back(32'h0000_00F0);
    n = 0;
    while (n < 10) begin
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL br_drain_valid got=%b exp=0", instr_valid); end
      if (imem_req) break;
      tick();
      n++;
    end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL br_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h0000_00F0) begin bad++; $display("FAIL br_addr got=%h exp=000000f0", imem_addr); end
    tick();
    n = 0;
    while (!instr_valid && n < 10) begin tick(); n++; end
    e = exp_q.pop_front();
    total++; if (instr_pc !== e) begin bad++; $display("FAIL br_pc got=%h exp=%h", instr_pc, e); end
    total++; if (instr !== ~e) begin bad++; $display("FAIL br_instr got=%h exp=%h", instr, ~e); end
  endtask

  task automatic test_jalr();
    mem_lat = 1;
    do_reset();
    tick();
    redirect_valid   = 1'b1;
    redirect_sel     = 1'b1;
    redirect_base_pc = 32'h0000_0500;
    imm_ext          = 32'h0000_0040;
    alu_result       = 32'h0000_2001;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL jalr_block_req got=%b exp=0", imem_req); end
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL jalr_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h0000_2000) begin bad++; $display("FAIL jalr_addr got=%h exp=00002000", imem_addr); end
    total++; if (misalign_fault !== 1'b0) begin bad++; $display("FAIL jalr_nofault got=%b exp=0", misalign_fault); end
    tick();
    redirect_valid = 1'b1;
    redirect_sel   = 1'b1;
    alu_result     = 32'h0000_2006;
    #1;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (misalign_fault !== 1'b1) begin bad++; $display("FAIL jalr_fault got=%b exp=1", misalign_fault); end
    total++; if (imem_addr !== 32'h0000_2000) begin bad++; $display("FAIL jalr_pc_hold got=%h exp=00002000", imem_addr); end
    for (int i = 0; i < 6; i++) begin
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_req got=%b exp=0", imem_req); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL halt_valid got=%b exp=0", instr_valid); end
      total++; if (misalign_fault !== 1'b1) begin bad++; $display("FAIL halt_fault got=%b exp=1", misalign_fault); end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    int n;
    mem_lat = 1;
    do_reset();
    exp_q.delete();
    total++; if (misalign_fault !== 1'b0) begin bad++; $display("FAIL wrap_fault_cleared got=%b exp=0", misalign_fault); end
    tick();
    redirect_valid   = 1'b1;
    redirect_sel     = 1'b0;
    redirect_base_pc = 32'hFFFF_FFFC;
    imm_ext          = 32'h0000_0008;
    #1;
    tick();
    redirect_valid = 1'b0;
    #1;
    exp_q.push_back(32'h0000_0004);
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL wrap_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h0000_0004) begin bad++; $display("FAIL wrap_addr got=%h exp=00000004", imem_addr); end
    n = 0;
    while (!instr_valid && n < 10) begin tick(); n++; end
    e = exp_q.pop_front();
    total++; if (instr_pc !== e) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", instr_pc, e); end
    total++; if (instr_pc_plus4 !== e + 32'd4) begin bad++; $display("FAIL wrap_pc4 got=%h exp=%h", instr_pc_plus4, e + 32'd4); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] e;
    int n;
    mem_lat = 1;
    do_reset();
    exp_q.delete();
    tick();
    tick();
    redirect_valid   = 1'b1;
    redirect_sel     = 1'b0;
    redirect_base_pc = 32'h0000_0040;
    imm_ext          = 32'h0000_0020;
    instr_ready      = 1'b1;
    #1;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    #1;
    exp_q.push_back(32'h0000_0060);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL sim_squash got=%b exp=0", instr_valid); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL sim_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h0000_0060) begin bad++; $display("FAIL sim_addr got=%h exp=00000060", imem_addr); end
    n = 0;
    while (!instr_valid && n < 10) begin tick(); n++; end
    e = exp_q.pop_front();
    total++; if (instr_pc !== e) begin bad++; $display("FAIL sim_pc got=%h exp=%h", instr_pc, e); end
    // Drain and redirect together: the drained slot must still read empty.
    instr_ready      = 1'b1;
    redirect_valid   = 1'b1;
    redirect_base_pc = 32'h0000_0200;
    imm_ext          = 32'h0000_0010;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL sim_drain_req got=%b exp=0", imem_req); end
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL sim_drain_squash got=%b exp=0", instr_valid); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL sim_drain_req2 got=%b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h0000_0210) begin bad++; $display("FAIL sim_drain_addr got=%h exp=00000210", imem_addr); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    int n;
    mem_lat = 1;
    do_reset();
    exp_q.delete();
    tick();
    tick();
    mem_lat = 3;
    tick();
    total++; if (imem_addr !== 32'h0000_0004) begin bad++; $display("FAIL mid_pre_addr got=%h exp=00000004", imem_addr); end
    tick();
    reset_n = 1'b0;
    #1;
    tick();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", instr_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL mid_instr got=%h exp=0", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL mid_pc got=%h exp=0", instr_pc); end
    total++; if (misalign_fault !== 1'b0) begin bad++; $display("FAIL mid_fault got=%b exp=0", misalign_fault); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mid_req got=%b exp=0", imem_req); end
    total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL mid_addr got=%h exp=%h", imem_addr, RESET_PC); end
    reset_n = 1'b1;
    #1;
    exp_q.push_back(RESET_PC);
    n = 0;
    while (!instr_valid && n < 15) begin tick(); n++; end
    e = exp_q.pop_front();
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL mid_refetch got=%b exp=1", instr_valid); end
    total++; if (instr_pc !== e) begin bad++; $display("FAIL mid_refetch_pc got=%h exp=%h", instr_pc, e); end
    total++; if (instr !== ~e) begin bad++; $display("FAIL mid_refetch_instr got=%h exp=%h", instr, ~e); end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_backpressure();
    test_branch_wait();
    test_jalr();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
